fetch_unit: RTL and testbench
=============================

# fetch_unit

Parametrised instruction-fetch engine sitting between the CPU control unit and program memory. It drives multi-cycle memory reads and reads variable-length instructions byte by byte into an instruction register. Each completed instruction is handed to the control unit over a valid/ready handshake. The block owns the program counter and supports configurable memory wait states, address wrap-around and jump-triggered flush.

## Interface
- ADDR_W, 16, address bus / PC width
- DATA_W, 8, memory data width (≥ 2)
- WAIT, 1, memory read strobe length in cycles per byte (≥ 1)
- RESET_PC, 0, PC value after reset
- MAX_LEN, 4, max instruction bytes; fixed at 4 (length field is 2 bits)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset; asynchronous, active-high
- mem_ce  out  1  memory chip enable
- mem_r  out  1  memory read strobe
- mem_oe  out  1  memory output enable
- addr_bus  out  ADDR_W  read address
- data_bus  in  DATA_W  read data from memory
- jmp_en  in  1  load jmp_addr into PC and flush
- jmp_addr  in  ADDR_W  jump target
- ir  out  4*DATA_W  instruction; byte k in [DATA_W*k +: DATA_W]
- ir_len  out  3  instruction length in bytes, 1..4
- ir_pc  out  ADDR_W  address of the instruction's first byte
- ir_valid  out  1  ir/ir_len/ir_pc valid
- ir_ready  in  1  control unit accepts the instruction
- pc  out  ADDR_W  address of the next byte to fetch

## Operation
- States: IDLE, RD, HOLD. Reset state is IDLE.
- IDLE -> RD unconditionally on the next edge.
- RD:
  - mem_ce = mem_r = mem_oe = 1 and addr_bus = pc.
  - Strobes are decoded from state and are low in IDLE and HOLD; addr_bus holds pc in all states.
  - A wait counter counts WAIT cycles per byte.
  - On the edge ending the last strobe cycle, data_bus is captured into ir byte k, and pc increments by 1 modulo 2^ADDR_W.
- Byte 0 is the opcode:
  - Length is opcode[DATA_W-1:DATA_W-2] + 1.
  - On byte 0 capture: ir_len is loaded, ir_pc is set to the fetch address, and ir bytes 1..3 are cleared to 0.
- After the last byte (k = len-1), go to HOLD with ir_valid = 1. Otherwise stay in RD for byte k+1.
- HOLD:
  - ir, ir_len, ir_pc and pc are stable; no memory access.
  - On an edge with ir_valid & ir_ready: ir_valid drops and the FSM goes to RD for the next instruction, with zero bubble.
- jmp_en (any state, sampled on the edge):
  - pc <= jmp_addr, ir_valid <= 0, byte index and wait counter reset, state <= RD.
  - A partially fetched instruction is discarded.
  - jmp_en has priority over a simultaneous ir handshake; that instruction counts as consumed.
- Reset values: mem_ce = mem_r = mem_oe = 0, ir_valid = 0, ir = 0, ir_len = 0, ir_pc = 0, pc = RESET_PC, addr_bus = RESET_PC.
- rst asserted mid-operation returns all of the above immediately (asynchronously), with no partial writes.

## Timing
- First strobe cycle is the 2nd cycle after rst deasserts (IDLE occupies the 1st).
- An N-byte instruction keeps strobes high for N*WAIT consecutive cycles.
- ir_valid rises in the cycle following the final capture edge.
- Per-byte address holds constant for WAIT cycles, then advances by 1.
- Back-to-back instructions with ir_ready held high: one cycle of ir_valid, then strobes resume the next cycle.
- After a jmp_en edge, addr_bus = jmp_addr and strobes are high in the next cycle.
- data_bus must be stable at the capture edge only.

## Test plan
- WAIT=2, RESET_PC=0, mem[0]=0x05, ir_ready=1 -> after 1 IDLE cycle, strobes high 2 cycles at addr 0; then ir_valid=1, ir=0x00000005, ir_len=1, ir_pc=0, pc=1.
- mem[1..3]=0x8A,0x34,0x12 -> addr sequence 1,1,2,2,3,3; then ir=0x0012348A, ir_len=3, ir_pc=1, pc=4.
- Backpressure: ir_ready=0 for 5 cycles in HOLD -> strobes 0, ir/pc unchanged; ir_ready=1 -> ir_valid drops and the next fetch starts at pc the following cycle.
- Jump mid-fetch: during byte 1 of a 4-byte opcode 0xC0, pulse jmp_en with jmp_addr=0x0100 -> next cycle addr_bus=0x0100, strobes high, ir_valid=0; only the instruction at 0x0100 is delivered.
- Wrap: RESET_PC=0xFFFF, mem[0xFFFF]=0x40, mem[0]=0x77 -> addresses 0xFFFF then 0x0000; ir=0x00007740, ir_len=2, ir_pc=0xFFFF, pc=0x0001.
- Assert rst mid-RD (WAIT=3, 2nd cycle) -> strobes 0 and pc=RESET_PC immediately; after release the fetch restarts cleanly from RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch engine: multi-cycle byte reads into an instruction register,
// valid/ready hand-off to control, PC ownership, jump flush.
module fetch_unit #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter int WAIT = 1,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int MAX_LEN = 4
) (
  input  logic                clk,
  input  logic                rst,
  output logic                mem_ce,
  output logic                mem_r,
  output logic                mem_oe,
  output logic [ADDR_W-1:0]   addr_bus,
  input  logic [DATA_W-1:0]   data_bus,
  input  logic                jmp_en,
  input  logic [ADDR_W-1:0]   jmp_addr,
  output logic [4*DATA_W-1:0] ir,
  output logic [2:0]          ir_len,
  output logic [ADDR_W-1:0]   ir_pc,
  output logic                ir_valid,
  input  logic                ir_ready,
  output logic [ADDR_W-1:0]   pc
);

  localparam int IW = $clog2(MAX_LEN);
  localparam int WW = (WAIT > 1) ? $clog2(WAIT) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RD,
    HOLD
  } state_t;

  state_t        state;
  logic [WW-1:0] wcnt;
  logic [IW-1:0] bidx;
  logic [IW-1:0] lm1;
  logic [IW-1:0] op;
  logic          wdone;
  logic          last;

  assign op    = data_bus[DATA_W-1 -: IW];
  assign wdone = (wcnt == WW'(WAIT - 1));
  // Byte 0 decides the length from the opcode on the bus itself
  assign last  = (bidx == ((bidx == '0) ? op : lm1));

  assign mem_ce   = (state == RD);
  assign mem_r    = (state == RD);
  assign mem_oe   = (state == RD);
  assign addr_bus = pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      wcnt     <= '0;
      bidx     <= '0;
      lm1      <= '0;
      pc       <= RESET_PC;
      ir       <= '0;
      ir_len   <= '0;
      ir_pc    <= '0;
      ir_valid <= 1'b0;
    end else if (jmp_en) begin
      state    <= RD;
      wcnt     <= '0;
      bidx     <= '0;
      pc       <= jmp_addr;
      ir_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: state <= RD;
        RD: begin
          if (!wdone) begin
            wcnt <= wcnt + 1'b1;
          end else begin
            wcnt <= '0;
            pc   <= pc + 1'b1;
            if (bidx == '0) begin
              ir     <= {{(3*DATA_W){1'b0}}, data_bus};
              ir_len <= {1'b0, op} + 3'd1;
              lm1    <= op;
              ir_pc  <= pc;
            end else begin
              for (int k = 1; k < 4; k++)
                if (k == int'(bidx))
                  ir[DATA_W*k +: DATA_W] <= data_bus;
            end
            if (last) begin
              bidx     <= '0;
              ir_valid <= 1'b1;
              state    <= HOLD;
            end else begin
              bidx <= bidx + 1'b1;
            end
          end
        end
        HOLD: begin
          if (ir_valid && ir_ready) begin
            ir_valid <= 1'b0;
            state    <= RD;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: basic fetch, multi-byte, backpressure,
// jump flush, address wrap and asynchronous reset mid-read.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst, rst2;
  logic        ce, r, oe, ce2, r2, oe2;
  logic [15:0] addr, addr2, pc, pc2, irpc, irpc2;
  logic [7:0]  data, data2;
  logic        jmp, jmp2;
  logic [15:0] jaddr, jaddr2;
  logic [31:0] ir, ir2;
  logic [2:0]  len, len2;
  logic        vld, vld2, rdy, rdy2;

  logic [7:0]  mem0 [65536];
  logic [7:0]  mem1 [65536];

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign data  = mem0[addr];
  assign data2 = mem1[addr2];

  fetch_unit #(.ADDR_W(16), .DATA_W(8), .WAIT(2), .RESET_PC(16'h0000)) u_dut (
    .clk(clk), .rst(rst), .mem_ce(ce), .mem_r(r), .mem_oe(oe),
    .addr_bus(addr), .data_bus(data), .jmp_en(jmp), .jmp_addr(jaddr),
    .ir(ir), .ir_len(len), .ir_pc(irpc), .ir_valid(vld),
    .ir_ready(rdy), .pc(pc)
  );

  fetch_unit #(.ADDR_W(16), .DATA_W(8), .WAIT(3), .RESET_PC(16'hFFFF)) u_wrap (
    .clk(clk), .rst(rst2), .mem_ce(ce2), .mem_r(r2), .mem_oe(oe2),
    .addr_bus(addr2), .data_bus(data2), .jmp_en(jmp2), .jmp_addr(jaddr2),
    .ir(ir2), .ir_len(len2), .ir_pc(irpc2), .ir_valid(vld2),
    .ir_ready(rdy2), .pc(pc2)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [15:0] seq0 [6];
    logic [15:0] seq1 [6];
    int cyc;
    seq0 = '{16'd1, 16'd1, 16'd2, 16'd2, 16'd3, 16'd3};
    seq1 = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0, 16'h0, 16'h0};
    for (int i = 0; i < 65536; i++) begin
      mem0[i] = 8'h00;
      mem1[i] = 8'h00;
    end
    mem0[0] = 8'h05;
    mem0[1] = 8'h8A; mem0[2] = 8'h34; mem0[3] = 8'h12;
    mem0[4] = 8'hC0; mem0[5] = 8'hAA; mem0[6] = 8'hBB; mem0[7] = 8'hCC;
    mem0[16'h100] = 8'h41; mem0[16'h101] = 8'h99;
    mem1[16'hFFFF] = 8'h40; mem1[0] = 8'h77; mem1[1] = 8'h03;
    rst = 1'b1; rst2 = 1'b1;
    rdy = 1'b1; rdy2 = 1'b0;
    jmp = 1'b0; jmp2 = 1'b0;
    jaddr = '0; jaddr2 = '0;

    repeat (2) @(negedge clk);
    chk("rst_strb", {ce, r, oe}, 3'b000);
    chk("rst_vld", vld, 1'b0);
    chk("rst_ir", ir, 32'h0);
    chk("rst_len", len, 3'd0);
    chk("rst_irpc", irpc, 16'h0);
    chk("rst_pc", pc, 16'h0);
    chk("rst_addr", addr, 16'h0);
    chk("rst2_pc", pc2, 16'hFFFF);
    chk("rst2_addr", addr2, 16'hFFFF);

    // first instruction: one byte, WAIT=2
    rst = 1'b0;
    #1 chk("idle_strb", {ce, r, oe}, 3'b000);
    @(negedge clk);
    chk("i0_strb0", {ce, r, oe}, 3'b111);
    chk("i0_addr0", addr, 16'h0);
    @(negedge clk);
    chk("i0_strb1", {ce, r, oe}, 3'b111);
    chk("i0_addr1", addr, 16'h0);
    @(negedge clk);
    chk("i0_vld", vld, 1'b1);
    chk("i0_strb", {ce, r, oe}, 3'b000);
    chk("i0_ir", ir, 32'h00000005);
    chk("i0_len", len, 3'd1);
    chk("i0_irpc", irpc, 16'h0);
    chk("i0_pc", pc, 16'h1);
    @(negedge clk);
    chk("i0_drop", vld, 1'b0);

    // three-byte instruction at 1
    for (int i = 0; i < 6; i++) begin
      chk("i1_addr", addr, seq0[i]);
      chk("i1_strb", {ce, r, oe}, 3'b111);
      rdy = 1'b0;
      @(negedge clk);
    end
    chk("i1_vld", vld, 1'b1);
    chk("i1_ir", ir, 32'h0012348A);
    chk("i1_len", len, 3'd3);
    chk("i1_irpc", irpc, 16'h1);
    chk("i1_pc", pc, 16'h4);

    // backpressure
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_vld", vld, 1'b1);
      chk("bp_strb", {ce, r, oe}, 3'b000);
      chk("bp_ir", ir, 32'h0012348A);
      chk("bp_pc", pc, 16'h4);
    end
    rdy = 1'b1;
    @(negedge clk);
    rdy = 1'b0;
    chk("bp_drop", vld, 1'b0);
    chk("bp_strb_on", {ce, r, oe}, 3'b111);
    chk("bp_addr", addr, 16'h4);

    // jump during byte 1 of a 4-byte opcode
    repeat (2) @(negedge clk);
    chk("j_pre_addr", addr, 16'h5);
    jmp = 1'b1; jaddr = 16'h0100;
    @(negedge clk);
    jmp = 1'b0;
    chk("j_addr", addr, 16'h0100);
    chk("j_strb", {ce, r, oe}, 3'b111);
    chk("j_vld", vld, 1'b0);
    cyc = 0;
    while (!vld && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("j_vld_rise", vld, 1'b1);
    chk("j_ir", ir, 32'h00009941);
    chk("j_len", len, 3'd2);
    chk("j_irpc", irpc, 16'h0100);
    chk("j_pc", pc, 16'h0102);

    // wrap-around with WAIT=3
    rst2 = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      chk("w_addr", addr2, seq1[i]);
      chk("w_strb", {ce2, r2, oe2}, 3'b111);
      @(negedge clk);
    end
    chk("w_vld", vld2, 1'b1);
    chk("w_ir", ir2, 32'h00007740);
    chk("w_len", len2, 3'd2);
    chk("w_irpc", irpc2, 16'hFFFF);
    chk("w_pc", pc2, 16'h0001);

    // reset in the 2nd strobe cycle of the next fetch
    rdy2 = 1'b1;
    @(negedge clk);
    rdy2 = 1'b0;
    chk("r_addr", addr2, 16'h0001);
    @(negedge clk);
    chk("r_strb_pre", {ce2, r2, oe2}, 3'b111);
    rst2 = 1'b1;
    #1;
    chk("r_strb", {ce2, r2, oe2}, 3'b000);
    chk("r_pc", pc2, 16'hFFFF);
    chk("r_vld", vld2, 1'b0);
    chk("r_ir", ir2, 32'h0);
    chk("r_len", len2, 3'd0);
    chk("r_irpc", irpc2, 16'h0);
    @(negedge clk);
    rst2 = 1'b0;
    @(negedge clk);
    chk("rr_strb", {ce2, r2, oe2}, 3'b111);
    chk("rr_addr", addr2, 16'hFFFF);
    cyc = 0;
    while (!vld2 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("rr_vld", vld2, 1'b1);
    chk("rr_ir", ir2, 32'h00007740);
    chk("rr_irpc", irpc2, 16'hFFFF);
    chk("rr_pc", pc2, 16'h0001);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
